// File: rtl/mem_pkg.sv
// mem_pkg: shared types and width helpers for the main-memory responder.
//   state_t : responder FSM states
//   op_t    : latched request kind
//   beat_width / cnt_width : derived widths (never below 1 bit)
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    WRESP  = 2'd2,
    RBURST = 2'd3
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  localparam int unsigned DEF_WORDS_PER_BLOCK = 4;
  localparam int unsigned DEF_LATENCY         = 4;

  // Beat index width: log2 of the burst length.
  function automatic int unsigned beat_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  // Latency counter width: clog2(LATENCY), kept at least 1 bit for LATENCY=1.
  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

  localparam int unsigned DEF_BEAT_W = beat_width(DEF_WORDS_PER_BLOCK);
  localparam int unsigned DEF_CNT_W  = cnt_width(DEF_LATENCY);

endpackage

// File: rtl/mem_latency_counter.sv
// mem_latency_counter: counts access-latency cycles, saturating at LATENCY-1.
//   clk    : clock
//   rst    : synchronous active-high reset
//   clear  : return count to 0 (takes priority over enable)
//   enable : advance count by one
//   done   : high while count == LATENCY-1
module mem_latency_counter
  import mem_pkg::*;
#(
  parameter int unsigned LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int unsigned CW = cnt_width(LATENCY);
  localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);

  logic [CW-1:0] count;

  // Saturating up-counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign done = (count == LAST);

endmodule

// File: rtl/main_memory_responder.sv
// main_memory_responder: fixed-latency main-memory model for the cache controller.
// Accepts one read-block or write-word request while idle, waits LATENCY cycles,
// then either commits the write and pulses Ready, or streams an aligned block.
//   CLK, RST   : clock, synchronous active-high reset
//   MemRead    : read-block request (sampled while Busy=0, wins over MemWrite)
//   MemWrite   : write-word request (sampled while Busy=0)
//   Address    : request word address
//   WriteData  : write word
//   Busy       : transaction in flight
//   Ready      : one-cycle completion pulse
//   RdValid, RdData, RdBeat : registered read beat stream
module main_memory_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 10,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter int unsigned LATENCY         = DEF_LATENCY
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic                                  MemRead,
  input  logic                                  MemWrite,
  input  logic [ADDR_WIDTH-1:0]                 Address,
  input  logic [DATA_WIDTH-1:0]                 WriteData,
  output logic                                  Busy,
  output logic                                  Ready,
  output logic                                  RdValid,
  output logic [DATA_WIDTH-1:0]                 RdData,
  output logic [beat_width(WORDS_PER_BLOCK)-1:0] RdBeat
);

  localparam int unsigned BW    = beat_width(WORDS_PER_BLOCK);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [BW-1:0]         LAST_BEAT  = BW'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_WIDTH-1:0] BLOCK_MASK = ADDR_WIDTH'(WORDS_PER_BLOCK - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state;
  state_t                next_state;
  op_t                   op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  cnt_done;
  logic                  cnt_clear;
  logic                  commit;

  logic                  busy_d;
  logic                  ready_d;
  logic                  rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic [BW-1:0]         rd_beat_d;
  logic [ADDR_WIDTH-1:0] rd_idx;

  // Counter restarts on every cycle outside WAIT and on the cycle WAIT ends.
  assign cnt_clear = (state != WAIT) || cnt_done;
  assign commit    = (state == WAIT) && cnt_done && (op_q == OP_WRITE);

  mem_latency_counter #(
    .LATENCY (LATENCY)
  ) u_latency (
    .clk    (CLK),
    .rst    (RST),
    .clear  (cnt_clear),
    .enable (state == WAIT),
    .done   (cnt_done)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (MemRead || MemWrite) next_state = WAIT;
      WAIT:    if (cnt_done) next_state = (op_q == OP_WRITE) ? WRESP : RBURST;
      WRESP:   next_state = IDLE;
      RBURST:  if (RdBeat == LAST_BEAT) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic: values the output registers take at the next edge.
  always_comb begin
    busy_d     = (next_state != IDLE);
    ready_d    = 1'b0;
    rd_valid_d = 1'b0;
    rd_beat_d  = '0;
    rd_data_d  = '0;
    rd_idx     = addr_q;
    unique case (next_state)
      WRESP: ready_d = 1'b1;
      RBURST: begin
        rd_valid_d = 1'b1;
        rd_beat_d  = (state == RBURST) ? (RdBeat + BW'(1)) : '0;
        // addr_q is block-aligned for reads, so OR-ing in the beat never wraps.
        rd_idx     = addr_q | ADDR_WIDTH'(rd_beat_d);
        rd_data_d  = mem[rd_idx];
        ready_d    = (rd_beat_d == LAST_BEAT);
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Busy    <= 1'b0;
      Ready   <= 1'b0;
      RdValid <= 1'b0;
      RdData  <= '0;
      RdBeat  <= '0;
    end else begin
      Busy    <= busy_d;
      Ready   <= ready_d;
      RdValid <= rd_valid_d;
      RdData  <= rd_data_d;
      RdBeat  <= rd_beat_d;
    end
  end

  // Request capture; a simultaneous write is dropped in favour of the read.
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE) begin
      if (MemRead) begin
        op_q   <= OP_READ;
        addr_q <= Address & ~BLOCK_MASK;
      end else if (MemWrite) begin
        op_q    <= OP_WRITE;
        addr_q  <= Address;
        wdata_q <= WriteData;
      end
    end
  end

  // Array write; contents are deliberately not reset.
  always_ff @(posedge CLK) begin
    if (!RST && commit) begin
      mem[addr_q] <= wdata_q;
    end
  end

endmodule
